// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multicycle CPU control path: state encodings,
// opcode/funct constants, ALU operation codes and datapath mux select codes.
// funct_legal() reports whether an R-type funct field names a supported op.
package mc_cpu_pkg;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEM_ADR = 4'd3;
  localparam logic [3:0] S_MEM_RD  = 4'd4;
  localparam logic [3:0] S_MEM_WR  = 4'd5;
  localparam logic [3:0] S_MEM_WB  = 4'd6;
  localparam logic [3:0] S_R_EXE   = 4'd7;
  localparam logic [3:0] S_R_WB    = 4'd8;
  localparam logic [3:0] S_I_EXE   = 4'd9;
  localparam logic [3:0] S_I_WB    = 4'd10;
  localparam logic [3:0] S_BR      = 4'd11;
  localparam logic [3:0] S_JUMP    = 4'd12;
  localparam logic [3:0] S_TRAP    = 4'd13;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_EQ  = 3'b110;
  localparam logic [2:0] ALU_NE  = 3'b111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_op_decode.sv
// ALU operation decode for the multicycle control FSM.
// Ports: state/opcode/funct in; alu_oprd (3b) and alu_ifslt out.
// Only R_EXE, I_EXE and BR drive a non-add operation; every other state
// yields add with ifslt clear, which is also the all-zero idle value.
import mc_cpu_pkg::*;

module mc_alu_op_decode (
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_oprd,
  output logic       alu_ifslt
);

  always_comb begin
    alu_oprd  = ALU_ADD;
    alu_ifslt = 1'b0;
    case (state)
      S_R_EXE: begin
        case (funct)
          F_SUB: alu_oprd = ALU_SUB;
          F_AND: alu_oprd = ALU_AND;
          F_OR:  alu_oprd = ALU_OR;
          F_XOR: alu_oprd = ALU_XOR;
          F_NOR: alu_oprd = ALU_NOR;
          F_SLT: begin
            alu_oprd  = ALU_SUB;
            alu_ifslt = 1'b1;
          end
          default: alu_oprd = ALU_ADD;
        endcase
      end
      S_I_EXE: begin
        case (opcode)
          OP_ANDI: alu_oprd = ALU_AND;
          OP_ORI:  alu_oprd = ALU_OR;
          default: alu_oprd = ALU_ADD;
        endcase
      end
      S_BR: alu_oprd = (opcode == OP_BNE) ? ALU_NE : ALU_EQ;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_alu_issue_ctrl.sv
// Multicycle CPU main control FSM (issuing side of the ALU interface).
// Sequences FETCH/DECODE/EXE/MEM/WB, handshakes memory via mem_ready and
// drives the datapath selects, ALU opcode and slt select.
// Ports: clk, rst (sync, active high), opcode/funct from IR, zero, mem_ready;
// outputs pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
// mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_oprd,
// alu_ifslt, state_o (debug) and, with ILLEGAL_TRAP_EN defined, illegal.
// ILLEGAL_TRAP_EN: unknown instructions lock into TRAP until reset instead
// of being retired as NOPs.
import mc_cpu_pkg::*;

module mc_alu_issue_ctrl #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [2:0]         alu_oprd,
  output logic               alu_ifslt,
  output logic [STATE_W-1:0] state_o
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic               illegal
`endif
);

  logic [3:0] state, nxt;
  logic       ready;
  logic [3:0] bad_dest;

  // Zero is consumed by the datapath (PC load qualified by pc_write_cond);
  // the FSM itself never branches on it.
  logic unused_zero;
  assign unused_zero = zero;

  assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

`ifdef ILLEGAL_TRAP_EN
  assign bad_dest = S_TRAP;
  assign illegal  = (state == S_TRAP);
`else
  assign bad_dest = S_FETCH;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  if (ready) nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:                      nxt = funct_legal(funct) ? S_R_EXE : bad_dest;
          OP_LW, OP_SW:              nxt = S_MEM_ADR;
          OP_BEQ, OP_BNE:            nxt = S_BR;
          OP_ADDI, OP_ANDI, OP_ORI:  nxt = S_I_EXE;
          OP_J:                      nxt = S_JUMP;
          default:                   nxt = bad_dest;
        endcase
      end
      S_MEM_ADR: nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  if (ready) nxt = S_MEM_WB;
      S_MEM_WR:  if (ready) nxt = S_FETCH;
      S_R_EXE:   nxt = S_R_WB;
      S_I_EXE:   nxt = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BR, S_JUMP: nxt = S_FETCH;
      S_TRAP:    nxt = S_TRAP;
      default:   nxt = S_IDLE;
    endcase
  end

  mc_alu_op_decode u_op_dec (
    .state     (state),
    .opcode    (opcode),
    .funct     (funct),
    .alu_oprd  (alu_oprd),
    .alu_ifslt (alu_ifslt)
  );

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_source     = PCS_ALU;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR and PC+4 commit only in the cycle the read is accepted.
        ir_write  = ready;
        pc_write  = ready;
      end
      S_DECODE:  alu_src_b = SRCB_IMM4;
      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_R_EXE:   alu_src_a = 1'b1;
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_I_EXE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_I_WB:    reg_write = 1'b1;
      S_BR: begin
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCS_JUMP;
      end
      default: ;
    endcase
  end

  assign state_o = STATE_W'(state);

endmodule

// File: tb/tb_mc_alu_issue_ctrl.sv
module tb_mc_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_ifslt;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_oprd;
  logic [3:0] state_o;
  logic       illegal_obs;

  mc_alu_issue_ctrl #(.MEM_HANDSHAKE(1), .STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_oprd(alu_oprd), .alu_ifslt(alu_ifslt),
    .state_o(state_o)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal_obs)
`endif
  );

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
  assign illegal_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  // Instruction steps as seen from the programmer's model of the sequence.
  typedef enum int {K_IDLE, K_FETCH, K_DEC, K_ADR, K_RD, K_WR, K_MWB,
                    K_REXE, K_RWB, K_IEXE, K_IWB, K_BR, K_J, K_TRAP} step_e;

  int n_cmp = 0;
  int n_bad = 0;
  step_e plan[$];
  bit rdy_q[$];
  logic [11:0] instr_q[$];   // {opcode, funct}
  int trap_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit op_known(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                      6'b001000, 6'b001100, 6'b001101, 6'b000010};
  endfunction

  function automatic bit fn_known(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                      6'b100110, 6'b100111, 6'b101010};
  endfunction

  // Steps an instruction goes through after FETCH and DECODE.
  task automatic build_plan(input logic [5:0] op, input logic [5:0] fn);
    plan = '{K_FETCH, K_DEC};
    if (!op_known(op) || (op == 6'b000000 && !fn_known(fn))) begin
      if (TRAP_ON) plan.push_back(K_TRAP);
    end else case (op)
      6'b000000: begin plan.push_back(K_REXE); plan.push_back(K_RWB); end
      6'b100011: begin plan.push_back(K_ADR); plan.push_back(K_RD); plan.push_back(K_MWB); end
      6'b101011: begin plan.push_back(K_ADR); plan.push_back(K_WR); end
      6'b000100, 6'b000101: plan.push_back(K_BR);
      6'b000010: plan.push_back(K_J);
      default: begin plan.push_back(K_IEXE); plan.push_back(K_IWB); end
    endcase
  endtask

  // Expected {illegal, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
  // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
  // pc_source, alu_oprd, alu_ifslt} for one step.
  function automatic logic [18:0] expect_out(input step_e s, input logic [5:0] op,
                                             input logic [5:0] fn, input bit rdy);
    logic ill, pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, slt;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    {ill, pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, slt} = '0;
    sb = 2'b00; ps = 2'b00; alu = 3'b000;
    case (s)
      K_FETCH: begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      K_DEC:   sb = 2'b11;
      K_ADR:   begin sa = 1; sb = 2'b10; end
      K_RD:    begin mr = 1; iod = 1; end
      K_WR:    begin mw = 1; iod = 1; end
      K_MWB:   begin rw = 1; m2r = 1; end
      K_REXE: begin
        sa = 1;
        case (fn)
          6'b100010: alu = 3'd1;
          6'b100100: alu = 3'd2;
          6'b100101: alu = 3'd3;
          6'b100110: alu = 3'd4;
          6'b100111: alu = 3'd5;
          6'b101010: begin alu = 3'd1; slt = 1; end
          default:   alu = 3'd0;
        endcase
      end
      K_RWB:   begin rw = 1; rd = 1; end
      K_IEXE:  begin sa = 1; sb = 2'b10; alu = (op == 6'b001100) ? 3'd2 : (op == 6'b001101) ? 3'd3 : 3'd0; end
      K_IWB:   rw = 1;
      K_BR:    begin sa = 1; pwc = 1; ps = 2'b01; alu = (op == 6'b000101) ? 3'd7 : 3'd6; end
      K_J:     begin pw = 1; ps = 2'b10; end
      K_TRAP:  ill = 1;
      default: ;
    endcase
    return {ill, pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ps, alu, slt};
  endfunction

  initial begin
    logic [18:0] exp_v, obs_v;
    logic [5:0] rop;
    bit rdy;
    step_e cur;
    static logic [5:0] legal_ops[9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
      6'b000101, 6'b001000, 6'b001100, 6'b001101, 6'b000010};
    static logic [5:0] legal_fns[7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
      6'b100110, 6'b100111, 6'b101010};

    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    trap_cycles = 0;
    // Directed instructions: slt, lw, bne, add, unknown opcode.
    instr_q = '{{6'b000000, 6'b101010}, {6'b100011, 6'b000000}, {6'b000101, 6'b000000},
                {6'b000000, 6'b100000}, {6'b111111, 6'b000000}};
    // mem_ready per cycle: IDLE | slt | lw (3 stall cycles in MEM_RD) | bne |
    // add with 2 FETCH stalls | unknown.
    rdy_q = '{1, 1,1,1,1, 1,1,1,0,0,0,1,1, 1,1,1, 0,0,1,1,1,1, 1,1};
    repeat (2) @(posedge clk);
    plan = '{K_IDLE};

    for (int cyc = 0; cyc < 3000; cyc++) begin
      #1;
      if (plan.size() == 0) begin
        if (instr_q.size() != 0) {opcode, funct} = instr_q.pop_front();
        else begin
          case ($urandom_range(0, 9))
            0: begin
              do rop = 6'($urandom); while (op_known(rop));
              opcode = rop; funct = 6'($urandom);
            end
            1: begin opcode = 6'b000000; funct = 6'($urandom); end
            default: begin
              opcode = legal_ops[$urandom_range(0, 8)];
              funct  = legal_fns[$urandom_range(0, 6)];
            end
          endcase
        end
        build_plan(opcode, funct);
      end
      if (rdy_q.size() != 0) begin
        rdy = rdy_q.pop_front();
        zero = 1'b1;
        rst = 1'b0;
      end else begin
        rdy = ($urandom_range(0, 9) < 6);
        zero = 1'($urandom);
        rst = ($urandom_range(0, 99) == 0) || (plan[0] == K_TRAP && trap_cycles >= 3);
      end
      mem_ready = rdy;
      @(negedge clk);
      cur = plan[0];
      exp_v = expect_out(cur, opcode, funct, rdy);
      obs_v = {illegal_obs, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               pc_source, alu_oprd, alu_ifslt};
      chk($sformatf("ctl_%s_cyc%0d", cur.name(), cyc), 32'(obs_v), 32'(exp_v));
      if (mem_read && mem_write) chk("rd_wr_exclusive", 32'({mem_read, mem_write}), 32'b10);
      if (rst) begin
        plan = '{K_IDLE};
        trap_cycles = 0;
      end else if (cur == K_TRAP) begin
        trap_cycles++;
      end else if (!((cur == K_FETCH || cur == K_RD || cur == K_WR) && !rdy)) begin
        void'(plan.pop_front());
      end
      @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
